// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-only data memory.
// Loads extract and extend a lane; SB/SH do read-modify-write of the whole word.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, next_state;
    logic [31:0] addr_q, data_q, word_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        store_q, err_q, req_err;
    logic [4:0]  lane_shift;
    logic [31:0] shifted, load_val, lane_mask, merged;

    always_comb begin
        req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
               || (req_funct3[2] && req_is_store)
               || (req_funct3[1:0] == 2'b01 && req_address[0])
               || (req_funct3[1:0] == 2'b10 && req_address[1:0] != 2'b00)
               || ({2'b00, req_address[31:2]} >= 32'(MEM_WORDS));
    end

    // Halfwords are 2-byte aligned, so a byte-granular shift also selects the half lane.
    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        shifted    = mem_read_data >> lane_shift;
        load_val   = funct3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                   : funct3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                   : funct3_q == 3'b100 ? {24'b0, shifted[7:0]}
                   : funct3_q == 3'b101 ? {16'b0, shifted[15:0]}
                   : shifted;
        lane_mask  = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merged     = (mem_read_data & ~(lane_mask << lane_shift))
                   | ((data_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = !req_valid ? IDLE
                              : req_err ? RESP
                              : (req_is_store && req_funct3 == 3'b010) ? WRITE
                              : READ;
            READ:  next_state = store_q ? WRITE : RESP;
            WRITE: next_state = RESP;
            RESP:  next_state = resp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            addr_q   <= req_address;
            data_q   <= req_write_data;
            funct3_q <= req_funct3;
            store_q  <= req_is_store;
            err_q    <= req_err;
            rdata_q  <= '0;
        end else if (state == READ) begin
            if (store_q) word_q  <= merged;
            else         rdata_q <= load_val;
        end
    end

    // Write strobe is gated by reset so a reset landing in WRITE suppresses the write.
    always_comb begin
        req_ready        = state == IDLE;
        resp_valid       = state == RESP;
        resp_read_data   = state == RESP ? rdata_q : '0;
        resp_error       = state == RESP && err_q;
        mem_address      = state == IDLE ? '0 : {2'b00, addr_q[31:2]};
        mem_write_enable = state == WRITE && !reset;
        mem_write_data   = state != WRITE ? '0 : funct3_q == 3'b010 ? data_q : word_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a behavioural word memory.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_is_store = 1'b0, resp_ready = 1'b1;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_address = '0, req_write_data = '0;
    logic        req_ready, resp_valid, resp_error, mem_write_enable;
    logic [31:0] resp_read_data, mem_address, mem_write_data, mem_read_data;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, wr_count = 0;
    logic [31:0] mem [64];

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_read_data(resp_read_data), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[5:0]];
    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[5:0]] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, wd,
                        input logic [31:0] ed, input logic ee, input int el);
        sb.push_back('{ed, ee, el});
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_address = a; req_write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] d, output logic e, output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = resp_read_data;
        e = resp_error;
        if (resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_write_enable} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1000", {req_ready, resp_valid, resp_error, mem_write_enable});
        end
        checks++;
        if ({resp_read_data, mem_address, mem_write_data} !== 96'd0) begin
            errors++;
            $display("FAIL reset_buses got %h %h %h exp 0", resp_read_data, mem_address, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8070, 32'hFFFF_8070, 32'h8070_6050};
        logic [31:0] d; logic e; int lat; exp_t x;
        mem[4] <= 32'h8070_6050;
        mem[5] <= 32'h1122_3344;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, f3[i], ad[i], 32'h0, ex[i], 1'b0, 2);
            collect(d, e, lat);
            x = sb.pop_front();
            checks++;
            if (d !== x.d || e !== x.e || lat !== x.lat) begin
                errors++;
                $display("FAIL load_%0d got %h/%b/%0d exp %h/%b/%0d", i, d, e, lat, x.d, x.e, x.lat);
            end
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] d; logic e; int lat; exp_t x; int w0;
        w0 = wr_count;
        send(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 32'h0, 1'b0, 3);
        collect(d, e, lat);
        x = sb.pop_front();
        checks++;
        if (d !== x.d || e !== x.e || lat !== x.lat) begin
            errors++;
            $display("FAIL sb_resp got %h/%b/%0d exp %h/%b/%0d", d, e, lat, x.d, x.e, x.lat);
        end
        checks++;
        if (mem[4] !== 32'h8070_AA50 || wr_count !== w0 + 1) begin
            errors++;
            $display("FAIL sb_mem got %h writes %0d exp 8070aa50 writes %0d", mem[4], wr_count - w0, 1);
        end
        send(1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 32'h0, 1'b0, 3);
        collect(d, e, lat);
        x = sb.pop_front();
        checks++;
        if (d !== x.d || e !== x.e || lat !== x.lat || mem[5] !== 32'hBEEF_3344) begin
            errors++;
            $display("FAIL sh_upper got %h/%b/%0d mem %h exp %h/%b/%0d mem beef3344", d, e, lat, mem[5], x.d, x.e, x.lat);
        end
    endtask

    task automatic test_store_word();
        logic [31:0] d; logic e; int lat; exp_t x; int w0;
        w0 = wr_count;
        send(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        collect(d, e, lat);
        x = sb.pop_front();
        checks++;
        if (d !== x.d || e !== x.e || lat !== x.lat || wr_count !== w0 + 1) begin
            errors++;
            $display("FAIL sw_resp got %h/%b/%0d writes %0d exp %h/%b/%0d writes 1", d, e, lat, wr_count - w0, x.d, x.e, x.lat);
        end
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        collect(d, e, lat);
        x = sb.pop_front();
        checks++;
        if (d !== x.d || e !== x.e || lat !== x.lat) begin
            errors++;
            $display("FAIL sw_readback got %h/%b/%0d exp %h/%b/%0d", d, e, lat, x.d, x.e, x.lat);
        end
    endtask

    task automatic test_errors();
        logic        st [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
        logic [31:0] ad [6] = '{32'h12, 32'h01, 32'h10, 32'h100, 32'h10, 32'hFC};
        logic [31:0] d; logic e; int lat; exp_t x; int w0;
        mem[63] <= 32'hA5A5_0001;
        w0 = wr_count;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) send(st[i], f3[i], ad[i], 32'h0, 32'hA5A5_0001, 1'b0, 2);
            else        send(st[i], f3[i], ad[i], 32'h1111_1111, 32'h0, 1'b1, 1);
            collect(d, e, lat);
            x = sb.pop_front();
            checks++;
            if (d !== x.d || e !== x.e || lat !== x.lat) begin
                errors++;
                $display("FAIL err_%0d got %h/%b/%0d exp %h/%b/%0d", i, d, e, lat, x.d, x.e, x.lat);
            end
        end
        checks++;
        if (wr_count !== w0) begin
            errors++;
            $display("FAIL err_no_write got %0d writes exp 0", wr_count - w0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat; exp_t x; int w0;
        w0 = wr_count;
        resp_ready = 1'b0;
        send(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        collect(d, e, lat);
        x = sb.pop_front();
        checks++;
        if (d !== x.d || e !== x.e || lat !== x.lat) begin
            errors++;
            $display("FAIL bp_resp got %h/%b/%0d exp %h/%b/%0d", d, e, lat, x.d, x.e, x.lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
            req_address = 32'h20; req_write_data = 32'h0000_0001;
            @(posedge clk); #1;
            checks++;
            if ({resp_valid, resp_error, req_ready} !== 3'b100 || resp_read_data !== x.d) begin
                errors++;
                $display("FAIL bp_hold_%0d got v%b e%b r%b %h exp v1 e0 r0 %h", i, resp_valid, resp_error, req_ready, resp_read_data, x.d);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got v%b r%b exp v0 r1", resp_valid, req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || wr_count !== w0) begin
            errors++;
            $display("FAIL bp_no_accept got v%b writes %0d exp v0 writes 0", resp_valid, wr_count - w0);
        end
    endtask

    task automatic test_reset_in_write();
        int w0;
        mem[8] <= 32'h1234_5678;
        @(negedge clk);
        w0 = wr_count;
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_address = 32'h21; req_write_data = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_write_enable !== 1'b1 || mem_write_data !== 32'h1234_5578) begin
            errors++;
            $display("FAIL rst_wr_merge got we%b %h exp we1 12345578", mem_write_enable, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_write_enable} !== 4'b1000
            || {resp_read_data, mem_address, mem_write_data} !== 96'd0) begin
            errors++;
            $display("FAIL rst_wr_state got r%b v%b e%b we%b %h %h %h exp r1 v0 e0 we0 0 0 0",
                     req_ready, resp_valid, resp_error, mem_write_enable, resp_read_data, mem_address, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_count !== w0 || mem[8] !== 32'h1234_5678 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_nowrite got writes %0d mem %h v%b exp writes 0 mem 12345678 v0", wr_count - w0, mem[8], resp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_store_byte();
        test_store_word();
        test_errors();
        test_backpressure();
        test_reset_in_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
